fp16_align_stage: RTL and testbench
===================================

Name: fp16_align_stage

Overview:
- Operand-alignment stage of the half-precision add/sub datapath.
- Sits directly upstream of magnitude16_sub.
- Unpacks two binary16 operands and applies the add/sub opcode to B's sign.
- Orders the operands so A has the larger exponent, right-shifts B's significand to the common exponent, and collects guard/round/sticky bits.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EB, 5, exponent width (fixed for binary16).
- MB, 11, significand width including hidden bit.
- SHIFT_SAT, 14, maximum alignment shift; larger differences saturate here.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  stage can accept operands this cycle.
- IN_OP_SUB  input  1  1 = A−B, 0 = A+B.
- IN_A  input  16  binary16 operand A.
- IN_B  input  16  binary16 operand B.
- OUT_VALID  output  1  aligned result valid.
- OUT_READY  input  1  downstream accepts result.
- OUT_SIGN_A  output  1  sign of larger-exponent operand.
- OUT_SIGN_B  output  1  sign of the other operand, after opcode applied.
- OUT_EXP_HALF  output  5  common (larger) biased exponent.
- OUT_MANT_A_HALF  output  11  unshifted significand of larger operand.
- OUT_MANT_B_HALF  output  11  aligned significand of smaller operand.
- OUT_GRS  output  3  [2] guard, [1] round, [0] sticky of bits shifted out of B.
- OUT_SWAPPED  output  1  1 = IN_B was placed on the A lane.
- OUT_SPECIAL  output  3  [2] NaN result, [1] Inf result, [0] invalid operation.

Behaviour:
- Reset:
  - RST high at a clock edge clears both stage valid bits.
  - All registered outputs go to 0; OUT_VALID=0.
  - IN_READY=1 in the cycle after reset.
  - RST mid-operation discards in-flight data with no output.
- Handshake:
  - Transfer in on IN_VALID&IN_READY; transfer out on OUT_VALID&OUT_READY.
  - Each stage loads when empty or when its successor advances in the same cycle.
  - IN_READY = !s1_valid | s1_advance (combinational from OUT_READY allowed).
  - Full throughput of 1 pair/cycle with OUT_READY high.
  - Data is never dropped or duplicated, and order is preserved.
  - Outputs stay stable while OUT_VALID & !OUT_READY.
- Latency: 2 cycles from accepted input to OUT_VALID when unstalled.
- Stage 1, unpack/compare:
  - sign_b_eff = IN_B[15] ^ IN_OP_SUB.
  - Normal operand: significand = {1, frac}, exponent = raw exponent.
  - Subnormal or zero (exp=0): significand = {0, frac}, effective exponent = 1.
  - Swap when expB > expA; equal exponents do not swap, because magnitude16_sub resolves significand order.
  - d = |expA − expB|, saturated to SHIFT_SAT.
  - Classify:
    - NaN if either input has exp=31 and frac≠0.
    - Inf − Inf with opposite effective signs → NaN and invalid.
    - Otherwise, any Inf → Inf.
- Stage 2, shift:
  - Form 14-bit {mant_b, 3'b000} and shift right by d.
  - Upper 11 bits → OUT_MANT_B_HALF; bit 2 → guard; bit 1 → round.
  - Sticky = bit 0 OR any bit shifted out.
  - d=0 gives GRS=000; d≥14 gives OUT_MANT_B_HALF=0 with sticky = (mant_b≠0).
  - Exponent and significand outputs pass through unchanged on special cases; downstream uses OUT_SPECIAL to override.
- Signs:
  - OUT_SIGN_A and OUT_SIGN_B carry the post-swap signs.
  - OUT_SIGN_B already includes the opcode.

Decomposition:
- Shared package fp16_pkg holds:
  - Constants: EXP_MAX=31, BIAS=15, MB=11, EB=5.
  - Field-slice helpers.
  - Special-flag bit indices, shared with magnitude16_sub FLAGS.
- One natural sub-module: fp_align_shift, a combinational right shifter with sticky (inputs: significand, shift amount; outputs: shifted significand, GRS). Reused later by the fp32 path.

Test Plan:
- 0x3C00 + 0x3C00, OP_SUB=0 → after 2 cycles: exp=15, mantA=mantB=0x400, signs 0/0, GRS=000, SWAPPED=0, SPECIAL=000.
- 0x3C00 + 0x3400 → exp=15, mantA=0x400, mantB=0x100, GRS=000; A=0x3C00 with B=0x3A01 (mant 0x601, d=1) → mantB=0x300, GRS=100.
- A=0x3400, B=0x3C00, OP_SUB=1 → SWAPPED=1, mantA=0x400, mantB=0x100, OUT_SIGN_A=1 (negated B), OUT_SIGN_B=0.
- A=0x3C00, B=0x0001 (min subnormal, d=14) → mantB=0x000, GRS=001; B=0x0000 → GRS=000.
- A=0x7C00, B=0x7C00, OP_SUB=1 → SPECIAL=101; OP_SUB=0 → SPECIAL=010; A=0x7E00 → SPECIAL[2]=1.
- Stream 4 pairs back-to-back with OUT_READY low for 3 cycles:
  - IN_READY drops once both stages are full.
  - Outputs hold steady, then drain in order with no loss.
- Assert RST during the stream: next cycle OUT_VALID=0 and IN_READY=1; the next accepted pair emerges 2 cycles later.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, field helpers and special-flag bit positions
// used by the fp16 add/sub datapath (alignment stage and magnitude16_sub).
package fp16_pkg;

    localparam int EB      = 5;
    localparam int MB      = 11;
    localparam int FRAC_W  = MB - 1;
    localparam int EXP_MAX = 31;
    localparam int BIAS    = 15;

    // Special-case flag layout, identical to the magnitude16_sub FLAGS bus
    localparam int SPC_W   = 3;
    localparam int SPC_NAN = 2;
    localparam int SPC_INF = 1;
    localparam int SPC_INV = 0;

    typedef struct packed {
        logic          sign;
        logic [EB-1:0] exp;     // effective exponent (subnormal/zero -> 1)
        logic [MB-1:0] mant;    // significand including hidden bit
        logic          is_nan;
        logic          is_inf;
    } fp16_unpacked_t;

    function automatic logic fp16_sign(input logic [15:0] h);
        return h[15];
    endfunction

    function automatic logic [EB-1:0] fp16_exp(input logic [15:0] h);
        return h[14:10];
    endfunction

    function automatic logic [FRAC_W-1:0] fp16_frac(input logic [15:0] h);
        return h[9:0];
    endfunction

    // Subnormals and zero share the exponent of the smallest normal so that
    // the alignment distance is computed on a uniform scale.
    function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] h);
        fp16_unpacked_t  u;
        logic [EB-1:0]     e;
        logic [FRAC_W-1:0] f;
        e        = fp16_exp(h);
        f        = fp16_frac(h);
        u.sign   = fp16_sign(h);
        u.exp    = (e == '0) ? EB'(1) : e;
        u.mant   = {(e != '0), f};
        u.is_nan = (e == EB'(EXP_MAX)) && (f != '0);
        u.is_inf = (e == EB'(EXP_MAX)) && (f == '0);
        return u;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter for significand alignment. Appends three
// zero bits below the significand, shifts right, and reports guard, round
// and sticky (sticky also absorbs every bit pushed off the bottom).
module fp_align_shift #(
    parameter int MB        = 11,
    parameter int SHIFT_SAT = 14,
    parameter int SW        = $clog2(SHIFT_SAT + 1)
) (
    input  logic [MB-1:0] mant_i,
    input  logic [SW-1:0] shift_i,
    output logic [MB-1:0] mant_o,
    output logic [2:0]    grs_o
);

    localparam int XW = MB + 3;

    logic [XW-1:0] ext;
    logic [XW-1:0] shifted;
    logic [XW-1:0] lost_mask;

    // Shift the extended significand and fold the discarded bits into sticky
    always_comb begin
        ext       = {mant_i, 3'b000};
        shifted   = ext >> shift_i;
        lost_mask = ~({XW{1'b1}} << shift_i);
        mant_o    = shifted[XW-1:3];
        grs_o     = {shifted[2], shifted[1], shifted[0] | (|(ext & lost_mask))};
        if (int'(shift_i) >= XW) begin
            mant_o = '0;
            grs_o  = {2'b00, |mant_i};
        end
    end

endmodule

// File: rtl/fp16_align_stage.sv
// Operand-alignment stage of the binary16 add/sub datapath. Stage 1 unpacks,
// applies the opcode to B's sign, orders operands by exponent and classifies
// specials; stage 2 aligns the smaller significand and collects GRS bits.
module fp16_align_stage #(
    parameter int EB        = 5,
    parameter int MB        = 11,
    parameter int SHIFT_SAT = 14
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic          IN_OP_SUB,
    input  logic [15:0]   IN_A,
    input  logic [15:0]   IN_B,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic          OUT_SIGN_A,
    output logic          OUT_SIGN_B,
    output logic [EB-1:0] OUT_EXP_HALF,
    output logic [MB-1:0] OUT_MANT_A_HALF,
    output logic [MB-1:0] OUT_MANT_B_HALF,
    output logic [2:0]    OUT_GRS,
    output logic          OUT_SWAPPED,
    output logic [2:0]    OUT_SPECIAL
);

    import fp16_pkg::*;

    localparam int SW = $clog2(SHIFT_SAT + 1);

    // |expA - expB| clamped to the largest useful alignment distance
    function automatic logic [SW-1:0] sat_shift(input logic signed [EB+1:0] diff);
        logic signed [EB+1:0] mag;
        mag = (diff < 0) ? -diff : diff;
        return (int'(mag) > SHIFT_SAT) ? SW'(SHIFT_SAT) : SW'(mag);
    endfunction

    // Inf - Inf with opposite effective signs is the only invalid operation
    function automatic logic [SPC_W-1:0] classify(input fp16_unpacked_t a,
                                                  input fp16_unpacked_t b,
                                                  input logic           sign_b_eff);
        logic [SPC_W-1:0] spc;
        logic             inv;
        logic             nan;
        inv          = a.is_inf & b.is_inf & (a.sign ^ sign_b_eff);
        nan          = a.is_nan | b.is_nan | inv;
        spc          = '0;
        spc[SPC_NAN] = nan;
        spc[SPC_INF] = ~nan & (a.is_inf | b.is_inf);
        spc[SPC_INV] = inv;
        return spc;
    endfunction

    // Handshake / valid tracking
    logic ld_p1;
    logic ld_p2;
    logic vld_p1_q, vld_p1_d;
    logic vld_p2_q, vld_p2_d;

    // Stage 1 results
    fp16_unpacked_t        ua;
    fp16_unpacked_t        ub;
    logic                  sign_b_eff;
    logic                  swap;
    logic signed [EB+1:0]  ediff;

    logic             sign_a_p1_q, sign_a_p1_d;
    logic             sign_b_p1_q, sign_b_p1_d;
    logic [EB-1:0]    exp_p1_q,    exp_p1_d;
    logic [MB-1:0]    mant_a_p1_q, mant_a_p1_d;
    logic [MB-1:0]    mant_b_p1_q, mant_b_p1_d;
    logic [SW-1:0]    shift_p1_q,  shift_p1_d;
    logic             swap_p1_q,   swap_p1_d;
    logic [SPC_W-1:0] spc_p1_q,    spc_p1_d;

    // Stage 2 (output) registers
    logic             sign_a_p2_q;
    logic             sign_b_p2_q;
    logic [EB-1:0]    exp_p2_q;
    logic [MB-1:0]    mant_a_p2_q;
    logic [MB-1:0]    mant_b_p2_q;
    logic [2:0]       grs_p2_q;
    logic             swap_p2_q;
    logic [SPC_W-1:0] spc_p2_q;

    logic [MB-1:0]    sh_mant;
    logic [2:0]       sh_grs;

    // Each stage loads when empty or when the stage after it drains this cycle
    always_comb begin
        ld_p2    = ~vld_p2_q | OUT_READY;
        IN_READY = ~vld_p1_q | ld_p2;
        ld_p1    = IN_READY & IN_VALID;
        vld_p1_d = IN_READY ? IN_VALID : vld_p1_q;
        vld_p2_d = ld_p2 ? vld_p1_q : vld_p2_q;
    end

    // Valid bits are the only state reset clears in the front stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // ---- stage 0 -> 1: unpack, apply opcode, order by exponent, classify
    // Equal exponents keep A on the A lane; magnitude16_sub orders significands.
    always_comb begin
        ua          = fp16_unpack(IN_A);
        ub          = fp16_unpack(IN_B);
        sign_b_eff  = ub.sign ^ IN_OP_SUB;
        swap        = (ub.exp > ua.exp);
        ediff       = signed'({2'b00, ua.exp}) - signed'({2'b00, ub.exp});
        sign_a_p1_d = swap ? sign_b_eff : ua.sign;
        sign_b_p1_d = swap ? ua.sign    : sign_b_eff;
        exp_p1_d    = swap ? ub.exp     : ua.exp;
        mant_a_p1_d = swap ? ub.mant    : ua.mant;
        mant_b_p1_d = swap ? ua.mant    : ub.mant;
        shift_p1_d  = sat_shift(ediff);
        swap_p1_d   = swap;
        spc_p1_d    = classify(ua, ub, sign_b_eff);
    end

    // Capture stage 1 on each accepted operand pair
    always_ff @(posedge CLK) begin
        if (ld_p1) begin
            sign_a_p1_q <= sign_a_p1_d;
            sign_b_p1_q <= sign_b_p1_d;
            exp_p1_q    <= exp_p1_d;
            mant_a_p1_q <= mant_a_p1_d;
            mant_b_p1_q <= mant_b_p1_d;
            shift_p1_q  <= shift_p1_d;
            swap_p1_q   <= swap_p1_d;
            spc_p1_q    <= spc_p1_d;
        end
    end

    // ---- stage 1 -> 2: align the smaller significand
    fp_align_shift #(
        .MB        (MB),
        .SHIFT_SAT (SHIFT_SAT),
        .SW        (SW)
    ) u_shift (
        .mant_i  (mant_b_p1_q),
        .shift_i (shift_p1_q),
        .mant_o  (sh_mant),
        .grs_o   (sh_grs)
    );

    // Output register: cleared on reset, held while the consumer stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            sign_a_p2_q <= 1'b0;
            sign_b_p2_q <= 1'b0;
            exp_p2_q    <= '0;
            mant_a_p2_q <= '0;
            mant_b_p2_q <= '0;
            grs_p2_q    <= '0;
            swap_p2_q   <= 1'b0;
            spc_p2_q    <= '0;
        end else if (ld_p2 && vld_p1_q) begin
            sign_a_p2_q <= sign_a_p1_q;
            sign_b_p2_q <= sign_b_p1_q;
            exp_p2_q    <= exp_p1_q;
            mant_a_p2_q <= mant_a_p1_q;
            mant_b_p2_q <= sh_mant;
            grs_p2_q    <= sh_grs;
            swap_p2_q   <= swap_p1_q;
            spc_p2_q    <= spc_p1_q;
        end
    end

    assign OUT_VALID       = vld_p2_q;
    assign OUT_SIGN_A      = sign_a_p2_q;
    assign OUT_SIGN_B      = sign_b_p2_q;
    assign OUT_EXP_HALF    = exp_p2_q;
    assign OUT_MANT_A_HALF = mant_a_p2_q;
    assign OUT_MANT_B_HALF = mant_b_p2_q;
    assign OUT_GRS         = grs_p2_q;
    assign OUT_SWAPPED     = swap_p2_q;
    assign OUT_SPECIAL     = spc_p2_q;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Bench for fp16_align_stage: directed vector table, stall/reset sequences
// and a randomized stream scored against an arithmetic reference model.
module tb_fp16_align_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_OP_SUB;
    logic [15:0] IN_A;
    logic [15:0] IN_B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_SIGN_A;
    logic        OUT_SIGN_B;
    logic [4:0]  OUT_EXP_HALF;
    logic [10:0] OUT_MANT_A_HALF;
    logic [10:0] OUT_MANT_B_HALF;
    logic [2:0]  OUT_GRS;
    logic        OUT_SWAPPED;
    logic [2:0]  OUT_SPECIAL;

    fp16_align_stage dut (
        .CLK             (CLK),
        .RST             (RST),
        .IN_VALID        (IN_VALID),
        .IN_READY        (IN_READY),
        .IN_OP_SUB       (IN_OP_SUB),
        .IN_A            (IN_A),
        .IN_B            (IN_B),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .OUT_SIGN_A      (OUT_SIGN_A),
        .OUT_SIGN_B      (OUT_SIGN_B),
        .OUT_EXP_HALF    (OUT_EXP_HALF),
        .OUT_MANT_A_HALF (OUT_MANT_A_HALF),
        .OUT_MANT_B_HALF (OUT_MANT_B_HALF),
        .OUT_GRS         (OUT_GRS),
        .OUT_SWAPPED     (OUT_SWAPPED),
        .OUT_SPECIAL     (OUT_SPECIAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        sa;
        logic        sb;
        logic [4:0]  ex;
        logic [10:0] ma;
        logic [10:0] mb;
        logic [2:0]  grs;
        logic        sw;
        logic [2:0]  spc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        exp_t        e;
    } vec_t;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    bit   chk_en      = 1'b0;

    function automatic exp_t observed();
        return {OUT_SIGN_A, OUT_SIGN_B, OUT_EXP_HALF, OUT_MANT_A_HALF,
                OUT_MANT_B_HALF, OUT_GRS, OUT_SWAPPED, OUT_SPECIAL};
    endfunction

    // Reference: exact integer division/remainder of the smaller significand
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
        exp_t r;
        int   ea, eb, ma, mb, bigm, smlm, d, scale, rem, frac8;
        logic sbe, an, bn, ai, bi, inv, nan;
        ea  = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
        eb  = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
        ma  = int'(a[9:0]) + ((a[14:10] != 5'd0) ? 1024 : 0);
        mb  = int'(b[9:0]) + ((b[14:10] != 5'd0) ? 1024 : 0);
        sbe = b[15] ^ op;
        if (eb > ea) begin
            r.sw = 1'b1; r.sa = sbe; r.sb = a[15]; r.ex = 5'(eb); bigm = mb; smlm = ma;
        end else begin
            r.sw = 1'b0; r.sa = a[15]; r.sb = sbe; r.ex = 5'(ea); bigm = ma; smlm = mb;
        end
        d = (ea > eb) ? ea - eb : eb - ea;
        if (d > 14) d = 14;
        scale = 1 << d;
        r.ma  = 11'(bigm);
        r.mb  = 11'(smlm / scale);
        rem   = smlm % scale;
        frac8 = (rem * 8) / scale;
        r.grs = {frac8[2], frac8[1], frac8[0] | (((rem * 8) % scale) != 0)};
        an  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
        bn  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
        ai  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
        bi  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
        inv = ai && bi && (a[15] != sbe);
        nan = an || bn || inv;
        r.spc = {nan, !nan && (ai || bi), inv};
        return r;
    endfunction

    task automatic check(input exp_t e, input string tag);
        exp_t o;
        o = observed();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL %s: got sa=%0b sb=%0b exp=%0d ma=%h mb=%h grs=%b sw=%0b spc=%b, want sa=%0b sb=%0b exp=%0d ma=%h mb=%h grs=%b sw=%0b spc=%b",
                     tag, o.sa, o.sb, o.ex, o.ma, o.mb, o.grs, o.sw, o.spc,
                     e.sa, e.sb, e.ex, e.ma, e.mb, e.grs, e.sw, e.spc);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Stream scoreboard: outputs compared against the oldest pending pair on
    // every cycle they are presented, popped only when accepted.
    always @(negedge CLK) begin
        if (RST) begin
            sb.delete();
        end else if (chk_en) begin
            if (OUT_VALID) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_out: got output with no pending pair, want none");
                end else begin
                    check(sb[0], "stream");
                    if (OUT_READY) void'(sb.pop_front());
                end
            end
            if (IN_VALID && IN_READY) sb.push_back(model(IN_A, IN_B, IN_OP_SUB));
        end
    end

    // Single pair through an idle pipe; called at posedge+1
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic op,
                         input exp_t e, input string tag);
        int n;
        IN_A = a; IN_B = b; IN_OP_SUB = op; IN_VALID = 1'b1; OUT_READY = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
            if (n == 1) IN_VALID = 1'b0;
        end while (!OUT_VALID && n < 10);
        check_int({tag, "_latency"}, n, 2);
        check(e, tag);
    endtask

    // Hold a pair on the input until accepted; called at posedge+1
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op);
        int n;
        IN_A = a; IN_B = b; IN_OP_SUB = op; IN_VALID = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!IN_READY && n < 200);
        if (!IN_READY) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got IN_READY=0 for %0d cycles, want 1", n);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check_int({tag, "_pending"}, sb.size(), 0);
    endtask

    function automatic logic [15:0] rnd_fp16(input logic [4:0] near);
        logic [15:0] h;
        int          k;
        h = 16'($urandom);
        k = $urandom_range(0, 15);
        if (k == 0)      h[14:10] = 5'd0;
        else if (k == 1) h[14:10] = 5'd31;
        else if (k == 2) h[14:0]  = {5'd31, 10'd0};
        else if (k == 3) h[14:0]  = 15'd0;
        else if (k < 10) h[14:10] = near + 5'($urandom_range(0, 6)) - 5'd3;
        return h;
    endfunction

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic op,
                                input logic sa, input logic sbit, input logic [4:0] ex,
                                input logic [10:0] ma, input logic [10:0] mb,
                                input logic [2:0] grs, input logic sw, input logic [2:0] spc);
        vec_t v;
        v.a = a; v.b = b; v.op = op;
        v.e = '{sa: sa, sb: sbit, ex: ex, ma: ma, mb: mb, grs: grs, sw: sw, spc: spc};
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[15];
        bit          done;
        logic [4:0]  ne;
        logic [15:0] ra, rb;

        RST = 1'b1; IN_VALID = 1'b0; IN_OP_SUB = 1'b0; IN_A = '0; IN_B = '0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_int("rst_out_valid", int'(OUT_VALID), 0);
        check_int("rst_in_ready", int'(IN_READY), 1);
        check('0, "rst_outputs");
        RST = 1'b0;

        //              A         B         op  sA    sB    exp    mantA     mantB     GRS     sw    special
        tbl[0]  = mk(16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h400, 3'b000, 1'b0, 3'b000);
        tbl[1]  = mk(16'h3C00, 16'h3400, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h100, 3'b000, 1'b0, 3'b000);
        tbl[2]  = mk(16'h3C00, 16'h3A01, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h300, 3'b100, 1'b0, 3'b000);
        tbl[3]  = mk(16'h3400, 16'h3C00, 1'b1, 1'b1, 1'b0, 5'd15, 11'h400, 11'h100, 3'b000, 1'b1, 3'b000);
        tbl[4]  = mk(16'h3C00, 16'h0001, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h000, 3'b001, 1'b0, 3'b000);
        tbl[5]  = mk(16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h000, 3'b000, 1'b0, 3'b000);
        tbl[6]  = mk(16'h7C00, 16'h7C00, 1'b1, 1'b0, 1'b1, 5'd31, 11'h400, 11'h400, 3'b000, 1'b0, 3'b101);
        tbl[7]  = mk(16'h7C00, 16'h7C00, 1'b0, 1'b0, 1'b0, 5'd31, 11'h400, 11'h400, 3'b000, 1'b0, 3'b010);
        tbl[8]  = mk(16'h7E00, 16'h3C00, 1'b0, 1'b0, 1'b0, 5'd31, 11'h600, 11'h000, 3'b001, 1'b0, 3'b100);
        tbl[9]  = mk(16'hC000, 16'h3C00, 1'b1, 1'b1, 1'b1, 5'd16, 11'h400, 11'h200, 3'b000, 1'b0, 3'b000);
        tbl[10] = mk(16'h3C00, 16'h3E00, 1'b0, 1'b0, 1'b0, 5'd15, 11'h400, 11'h600, 3'b000, 1'b0, 3'b000);
        tbl[11] = mk(16'h0200, 16'h0400, 1'b0, 1'b0, 1'b0, 5'd1,  11'h200, 11'h400, 3'b000, 1'b0, 3'b000);
        tbl[12] = mk(16'h7C00, 16'hFC00, 1'b0, 1'b0, 1'b1, 5'd31, 11'h400, 11'h400, 3'b000, 1'b0, 3'b101);
        tbl[13] = mk(16'h3C00, 16'h7C00, 1'b0, 1'b0, 1'b0, 5'd31, 11'h400, 11'h000, 3'b001, 1'b1, 3'b010);
        tbl[14] = mk(16'h4800, 16'h3BFF, 1'b0, 1'b0, 1'b0, 5'd18, 11'h400, 11'h07F, 3'b111, 1'b0, 3'b000);

        for (int i = 0; i < 15; i++)
            apply(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e, $sformatf("tbl%0d", i));

        // Four pairs back-to-back while the consumer stalls for three edges
        @(posedge CLK); #1;
        chk_en = 1'b1;
        OUT_READY = 1'b0;
        fork
            begin
                send(16'h3C00, 16'h3400, 1'b0);
                send(16'h4000, 16'h3A01, 1'b1);
                send(16'h3400, 16'h4400, 1'b0);
                send(16'hBC00, 16'h0001, 1'b1);
            end
            begin
                repeat (3) @(negedge CLK);
                check_int("stall_in_ready", int'(IN_READY), 0);
                check_int("stall_out_valid", int'(OUT_VALID), 1);
                @(posedge CLK); #1;
                OUT_READY = 1'b1;
            end
        join
        drain("stall");

        // Randomized stream with random input gaps and consumer backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge CLK); #1;
                    end
                    ne = 5'($urandom_range(0, 31));
                    ra = rnd_fp16(ne);
                    rb = rnd_fp16(ne);
                    send(ra, rb, 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge CLK); #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        OUT_READY = 1'b1;
        drain("random");

        // Reset while two pairs are in flight
        IN_A = 16'h3C00; IN_B = 16'h3400; IN_OP_SUB = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_A = 16'h4000; IN_B = 16'h3C00; IN_OP_SUB = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_int("midrst_out_valid", int'(OUT_VALID), 0);
        check_int("midrst_in_ready", int'(IN_READY), 1);
        RST = 1'b0;
        chk_en = 1'b0;
        apply(16'h4400, 16'h3800, 1'b1, model(16'h4400, 16'h3800, 1'b1), "after_rst");
        @(posedge CLK); #1;
        check_int("after_rst_empty", int'(OUT_VALID), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
